// File: rtl/axis_pkg.sv
// axis_pkg: shared AXI-Stream beat type and packet-FIFO write FSM states
package axis_pkg;
  localparam int AXIS_DATA_W = 512;
  localparam int AXIS_KEEP_W = AXIS_DATA_W / 8;
  localparam int AXIS_USER_W = 1;
  typedef struct packed {
    logic [AXIS_DATA_W-1:0] data;
    logic [AXIS_KEEP_W-1:0] keep;
    logic                   last;
    logic [AXIS_USER_W-1:0] user;
  } axis_beat_t;
  typedef enum logic [1:0] {WR_IDLE, WR_PKT, WR_DROP} wr_state_e;
endpackage

// File: rtl/axis_out_skid.sv
// axis_out_skid: two-entry registered skid stage between a ready/valid source and an AXIS master
module axis_out_skid
  import axis_pkg::*;
#(
  parameter type T = axis_beat_t
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic s_valid,
  output logic s_ready,
  input  T     s_data,
  output logic m_valid,
  input  logic m_ready,
  output T     m_data
);
  T     d1;
  logic v1;
  assign s_ready = !v1;
  // output register refills from the spare entry first, otherwise straight from the source
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      v1      <= 1'b0;
      d1      <= '0;
    end else if (!m_valid || m_ready) begin
      m_valid <= v1 | s_valid;
      if (v1 || s_valid) m_data <= v1 ? d1 : s_data;
      v1 <= 1'b0;
    end else if (s_valid && !v1) begin
      d1 <= s_data;
      v1 <= 1'b1;
    end
  end
endmodule

// File: rtl/axis_pkt_fifo_sf.sv
// axis_pkt_fifo_sf: store-and-forward AXI-Stream packet FIFO that drops errored and oversize packets
module axis_pkt_fifo_sf
  import axis_pkg::*;
#(
  parameter int DATA_W      = 512,
  parameter int KEEP_W      = DATA_W / 8,
  parameter int USER_W      = 1,
  parameter int DEPTH       = 64,
  parameter bit DROP_ON_ERR = 1'b1
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  output logic                    s0_tready,
  input  logic                    s0_tvalid,
  input  logic [DATA_W-1:0]       s0_tdata,
  input  logic [KEEP_W-1:0]       s0_tkeep,
  input  logic                    s0_tlast,
  input  logic [USER_W-1:0]       s0_tuser,
  input  logic                    m0_tready,
  output logic                    m0_tvalid,
  output logic [DATA_W-1:0]       m0_tdata,
  output logic [KEEP_W-1:0]       m0_tkeep,
  output logic                    m0_tlast,
  output logic [USER_W-1:0]       m0_tuser,
  output logic [$clog2(DEPTH):0]  pkt_count,
  output logic                    drop_pulse,
  output logic                    ovf_pulse
);
  localparam int AW = $clog2(DEPTH);
  typedef logic [AW:0] ptr_t;
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
    logic [USER_W-1:0] user;
  } beat_t;
  localparam ptr_t ONE  = ptr_t'(1);
  localparam ptr_t FULL = ptr_t'(DEPTH);
  beat_t     mem [DEPTH];
  beat_t     ram_q, m_beat;
  ptr_t      wr_cur, wr_com, rd_ptr, rd_addr;
  wr_state_e state, state_nxt;
  logic      live, acc, we, commit, rewind, oversize, err;
  logic      rd_vld, ren, sk_ready, m_fire;
  // rd_ptr frees a slot only once its beat leaves m0, so prefetched beats still count as occupied
  always_comb begin
    err       = DROP_ON_ERR & s0_tuser[0];
    s0_tready = live & ((state == WR_DROP) | ((wr_cur - rd_ptr) != FULL));
    acc       = s0_tvalid & s0_tready;
    oversize  = (wr_cur + ONE - wr_com) == FULL;
    rewind    = acc & (state != WR_DROP) & (s0_tlast ? err : oversize);
    we        = acc & (state != WR_DROP) & !rewind;
    commit    = we & s0_tlast;
  end
  // write FSM next state: a non-last beat that would overflow the buffer diverts into discard mode
  always_comb begin
    state_nxt = !acc ? state : s0_tlast ? WR_IDLE :
                (state == WR_DROP || oversize) ? WR_DROP : WR_PKT;
  end
  // write FSM state register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= WR_IDLE;
    else state <= state_nxt;
  end
  // write pointers, packet counter and drop indications
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      live       <= 1'b0;
      wr_cur     <= '0;
      wr_com     <= '0;
      pkt_count  <= '0;
      drop_pulse <= 1'b0;
      ovf_pulse  <= 1'b0;
    end else begin
      live       <= 1'b1;
      wr_cur     <= rewind ? wr_com : we ? wr_cur + ONE : wr_cur;
      if (commit) wr_com <= wr_cur + ONE;
      pkt_count  <= pkt_count + ptr_t'(commit) - ptr_t'(m_fire & m0_tlast);
      drop_pulse <= rewind & s0_tlast;
      ovf_pulse  <= rewind & !s0_tlast;
    end
  end
  // storage array with registered read port
  always_ff @(posedge aclk) begin
    if (we) mem[wr_cur[AW-1:0]] <= {s0_tdata, s0_tkeep, s0_tlast, s0_tuser};
    if (ren) ram_q <= mem[rd_addr[AW-1:0]];
  end
  assign m_fire = m0_tvalid & m0_tready;
  assign ren    = (rd_addr != wr_com) & (!rd_vld | sk_ready);
  // read pointers: rd_addr fetches committed beats, rd_ptr follows beats accepted on m0
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_addr <= '0;
      rd_ptr  <= '0;
      rd_vld  <= 1'b0;
    end else begin
      if (ren) rd_addr <= rd_addr + ONE;
      if (ren || sk_ready) rd_vld <= ren;
      rd_ptr <= rd_ptr + ptr_t'(m_fire);
    end
  end
  axis_out_skid #(.T(beat_t)) u_skid (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s_valid (rd_vld),
    .s_ready (sk_ready),
    .s_data  (ram_q),
    .m_valid (m0_tvalid),
    .m_ready (m0_tready),
    .m_data  (m_beat)
  );
  assign m0_tdata = m_beat.data;
  assign m0_tkeep = m_beat.keep;
  assign m0_tlast = m_beat.last;
  assign m0_tuser = m_beat.user;
endmodule

// File: doc/axis_pkt_fifo_sf.md
Name: axis_pkt_fifo_sf

Overview:
Store-and-forward AXI-Stream packet FIFO that sits directly downstream of the 3:1 round-robin packet mux. It consumes the mux's merged m0 stream and presents a packet on its own master port only after the packet's tlast beat is stored. Packets flagged with an error in tuser[0] on the last beat are dropped. Packets longer than the buffer are dropped rather than deadlocking the mux. This guarantees the next stage never sees a partial or errored packet and never stalls mid-packet on the input side.

Parameters:
DATA_W, 512, tdata width
KEEP_W, DATA_W/8, tkeep width
USER_W, 1, tuser width; bit 0 is the error flag
DEPTH, 64, storage entries (beats); power of 2, >= 4
DROP_ON_ERR, 1, 1 = discard packets whose last beat has tuser[0]=1; 0 = forward them

Ports:
aclk  in  1  clock
aresetn  in  1  reset
s0_tready  out  1  slave ready
s0_tvalid  in  1  slave valid
s0_tdata  in  DATA_W  slave data
s0_tkeep  in  KEEP_W  slave byte enables
s0_tlast  in  1  slave end of packet
s0_tuser  in  USER_W  slave user/error
m0_tready  in  1  master ready
m0_tvalid  out  1  master valid
m0_tdata  out  DATA_W  master data
m0_tkeep  out  KEEP_W  master byte enables
m0_tlast  out  1  master end of packet
m0_tuser  out  USER_W  master user
pkt_count  out  $clog2(DEPTH)+1  committed packets currently stored
drop_pulse  out  1  1-cycle pulse when an error packet is discarded
ovf_pulse  out  1  1-cycle pulse when an oversize packet is discarded

Behaviour:
- Clock and reset: single clock aclk. aresetn is an asynchronous, active-low reset.
- Reset: all outputs 0; pointers, FSM, output stage and counters cleared. Reset mid-packet silently loses the partial packet and all stored data.
- Storage: DEPTH x {tdata,tkeep,tlast,tuser}. Three pointers, each ADDR_W+1 bits wide with wrap bit:
  - wr_cur: speculative write pointer.
  - wr_com: committed write pointer.
  - rd_ptr: read pointer.
- Accept rule: a beat is accepted when s0_tvalid & s0_tready on a rising edge.
- Write FSM:
  - WR_IDLE / WR_PKT:
    - s0_tready = (wr_cur - rd_ptr) != DEPTH.
    - Each accepted beat is written at wr_cur, then wr_cur++.
    - The first accepted beat moves IDLE->PKT.
  - Commit (tlast accepted, normal case): wr_com <= wr_cur+1; return to WR_IDLE.
  - Error drop (tlast accepted with tuser[0]=1 and DROP_ON_ERR=1):
    - wr_cur <= wr_com (rewind); wr_com unchanged.
    - drop_pulse=1 for the following cycle; return to WR_IDLE.
  - Oversize: if a non-last beat is accepted when (wr_cur+1 - wr_com) == DEPTH:
    - wr_cur <= wr_com; go to WR_DROP; ovf_pulse=1 for one cycle.
  - WR_DROP:
    - s0_tready=1; beats are discarded.
    - On accepted tlast, go to WR_IDLE.
- Read side:
  - Data available when rd_ptr != wr_com.
  - Synchronous RAM read feeds a 2-entry output skid so m0 sustains 1 beat/clk with m0_tready=1.
  - m0 outputs are registered.
- Latency: tlast accepted at edge N puts the first beat on m0 (m0_tvalid=1) after edge N+2. Subsequent beats follow back-to-back.
- AXIS rules:
  - m0_tvalid never deasserts and m0 payload never changes while m0_tready=0.
  - Packet order preserved; beat content bit-exact.
- pkt_count:
  - +1 on commit; -1 when the m0 beat with tlast is accepted.
  - Both in the same cycle leaves it unchanged.
  - A dropped packet never changes it.
- Full buffer with m0_tready=0: s0_tready=0 until space frees. The input never stalls in WR_DROP.
- Simultaneous write and read of the same address on an empty FIFO: cannot occur, because reads only see committed entries.
- Throughput: 1 beat/clk input when not full.

Decomposition:
- Package axis_pkg: AXIS beat struct typedef (data/keep/last/user) and the write FSM state enum (WR_IDLE, WR_PKT, WR_DROP).
- Sub-module axis_out_skid: 2-entry output register/skid buffer with ready/valid on both sides, instantiated once for the m0 stage.

Test Plan:
- One 3-beat packet, tdata 0xA0/0xA1/0xA2, m0_tready=1 -> m0_tvalid=0 until tlast is stored; beats appear on 3 consecutive cycles starting 2 edges after tlast accept; pkt_count goes 0->1->0.
- 4-beat packet with tuser[0]=1 on the last beat, then a 2-beat good packet -> no m0 output for the first; drop_pulse high for exactly 1 cycle; the good packet is output intact; pkt_count never exceeds 1.
- DEPTH=16, 20-beat packet, then a 3-beat packet -> ovf_pulse once on beat 16 accept; s0_tready stays 1 throughout; only the 3-beat packet emerges.
- m0_tready=0, push 16 single-beat packets (DEPTH=16) -> s0_tready=0 after 16 accepts, pkt_count=16; release m0_tready -> all 16 emerge in order and s0_tready reasserts.
- Commit of packet B on the same cycle as the tlast pop of packet A -> pkt_count holds at 1.
- Assert aresetn=0 mid-packet (beat 2 of 5) with one committed packet stored -> all outputs 0 immediately; after release, the FIFO is empty and the next packet passes normally.
